// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants for the pipelined data memory with dump port.
//   - dump FSM state encodings (ST_IDLE, ST_DUMP, ST_DRAIN, ST_DONE)
//   - read-pipeline source tags (SRC_CPU, SRC_DUMP)
//   - RD_LAT_MAX, the deepest supported read latency
//   - byteLanes(): number of byte lanes in a data word
package dmem_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DUMP  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic SRC_CPU  = 1'b0;
    localparam logic SRC_DUMP = 1'b1;

    localparam int RD_LAT_MAX = 4;
    localparam int BYTE_W     = 8;

    function automatic int byteLanes(input int dataW);
        return dataW / BYTE_W;
    endfunction

endpackage

// File: rtl/dmem_pipe_dump_if.sv
// dmem_pipe_dump_if: cpu data-memory port plus the dump stream port.
//   master : cpu/bench side, drives requests and dumpStart
//   slave  : memory side, drives read data and the dump stream
// Vectors are big-endian ([0:N-1]); byte lane i of a word is bits [8i:8i+7].
interface dmem_pipe_dump_if #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8
);
    localparam int NB = DATA_W / 8;

    logic              memEn;
    logic              memWrEn;
    logic [0:ADDR_W-1] memAddr;
    logic [0:DATA_W-1] dataIn;
    logic [0:NB-1]     byteWrMask;
    logic [0:DATA_W-1] dataOut;
    logic              dataValid;

    logic              dumpStart;
    logic              dumpBusy;
    logic              dumpValid;
    logic [0:ADDR_W-1] dumpAddr;
    logic [0:DATA_W-1] dumpData;
    logic              dumpDone;

    modport master (
        output memEn, memWrEn, memAddr, dataIn, byteWrMask, dumpStart,
        input  dataOut, dataValid, dumpBusy, dumpValid, dumpAddr, dumpData, dumpDone
    );

    modport slave (
        input  memEn, memWrEn, memAddr, dataIn, byteWrMask, dumpStart,
        output dataOut, dataValid, dumpBusy, dumpValid, dumpAddr, dumpData, dumpDone
    );

endinterface

// File: rtl/dmem_rd_pipe.sv
// dmem_rd_pipe: RD_LAT-deep shift register carrying {valid, tag, addr, data}
// for reads issued against the storage array.
//   clk, reset        : clock, synchronous active-low reset (flushes valids)
//   inVld/inTag/...   : read issued this cycle, data already sampled from array
//   outVld/outTag/... : entry that has spent RD_LAT-1 cycles in the pipe
//   dumpInFlight      : some dump-tagged read is still in the pipe
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inVld,
    input  logic              inTag,
    input  logic [0:ADDR_W-1] inAddr,
    input  logic [0:DATA_W-1] inData,
    output logic              outVld,
    output logic              outTag,
    output logic [0:ADDR_W-1] outAddr,
    output logic [0:DATA_W-1] outData,
    output logic              dumpInFlight
);

    logic [RD_LAT:1]                 vldPipe;
    logic [RD_LAT:1]                 tagPipe;
    logic [RD_LAT:1][0:ADDR_W-1]     addrPipe;
    logic [RD_LAT:1][0:DATA_W-1]     dataPipe;

    always_ff @(posedge clk) begin
        if (!reset) begin
            vldPipe <= '0;
        end else begin
            vldPipe[1] <= inVld;
            for (int k = 2; k <= RD_LAT; k++) vldPipe[k] <= vldPipe[k-1];
        end
    end

    // Payload is qualified by vldPipe, so it needs no reset.
    always_ff @(posedge clk) begin
        tagPipe[1]  <= inTag;
        addrPipe[1] <= inAddr;
        dataPipe[1] <= inData;
        for (int k = 2; k <= RD_LAT; k++) begin
            tagPipe[k]  <= tagPipe[k-1];
            addrPipe[k] <= addrPipe[k-1];
            dataPipe[k] <= dataPipe[k-1];
        end
    end

    always_comb begin
        dumpInFlight = 1'b0;
        for (int k = 1; k <= RD_LAT; k++)
            if (vldPipe[k] && tagPipe[k] == SRC_DUMP) dumpInFlight = 1'b1;
    end

    assign outVld  = vldPipe[RD_LAT];
    assign outTag  = tagPipe[RD_LAT];
    assign outAddr = addrPipe[RD_LAT];
    assign outData = dataPipe[RD_LAT];

endmodule

// File: rtl/dmem_pipe_dump.sv
// dmem_pipe_dump: single-port data memory with byte-lane write masking,
// configurable read latency and a dump sequencer that streams every word.
//   clk, reset : rising-edge clock, synchronous active-low reset
//   bus        : dmem_pipe_dump_if.slave (cpu port + dump port)
// The array is never reset so preloaded contents survive reset. Cpu accesses
// always win the port; the dump only issues on cycles with memEn low. Both
// read sources share one pipeline and are split by tag at the output.
module dmem_pipe_dump
    import dmem_pkg::*;
#(
    parameter int DATA_W       = 64,
    parameter int ADDR_W       = 8,
    parameter int RD_LAT       = 1,
    parameter int BYTE_MASK_EN = 1
) (
    input  logic            clk,
    input  logic            reset,
    dmem_pipe_dump_if.slave bus
);

    localparam int NB    = byteLanes(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    generate
        if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : gBadLat
            $error("dmem_pipe_dump: RD_LAT must be in 1..%0d", RD_LAT_MAX);
        end
        if (DATA_W % 8 != 0 || DATA_W < 8) begin : gBadWidth
            $error("dmem_pipe_dump: DATA_W must be a positive multiple of 8");
        end
    endgenerate

    logic [0:DATA_W-1] mem [0:DEPTH-1];

    logic              cpuWr;
    logic              cpuRd;
    logic [0:NB-1]     wrMask;
    logic              dumpIssue;

    logic              issueVld;
    logic              issueTag;
    logic [0:ADDR_W-1] issueAddr;
    logic [0:DATA_W-1] issueData;

    logic              pVld;
    logic              pTag;
    logic [0:ADDR_W-1] pAddr;
    logic [0:DATA_W-1] pData;
    logic              dumpInFlight;

    logic [1:0]        state;
    logic [0:ADDR_W-1] dumpCnt;

    logic [0:DATA_W-1] dataOutQ;
    logic              dataValidQ;
    logic              dumpValidQ;
    logic [0:ADDR_W-1] dumpAddrQ;
    logic [0:DATA_W-1] dumpDataQ;

    assign cpuWr     = bus.memEn & bus.memWrEn;
    assign cpuRd     = bus.memEn & ~bus.memWrEn;
    assign wrMask    = (BYTE_MASK_EN != 0) ? bus.byteWrMask : '1;
    // Cpu access in this cycle steals the port from the dump.
    assign dumpIssue = (state == ST_DUMP) & ~bus.memEn;

    // Array write: lands at the same edge, so a read issued on the next
    // cycle already sees the new word.
    always_ff @(posedge clk) begin
        if (reset && cpuWr) begin
            for (int i = 0; i < NB; i++)
                if (wrMask[i]) mem[bus.memAddr][8*i +: 8] <= bus.dataIn[8*i +: 8];
        end
    end

    // Read issue: data is sampled from the array now, which makes each dump
    // word a snapshot taken at its issue cycle.
    always_comb begin
        issueVld  = cpuRd | dumpIssue;
        issueTag  = dumpIssue ? SRC_DUMP : SRC_CPU;
        issueAddr = dumpIssue ? dumpCnt : bus.memAddr;
        issueData = mem[issueAddr];
    end

    dmem_rd_pipe #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) uRdPipe (
        .clk          (clk),
        .reset        (reset),
        .inVld        (issueVld),
        .inTag        (issueTag),
        .inAddr       (issueAddr),
        .inData       (issueData),
        .outVld       (pVld),
        .outTag       (pTag),
        .outAddr      (pAddr),
        .outData      (pData),
        .dumpInFlight (dumpInFlight)
    );

    // Output stage: the final register of the RD_LAT latency. Data/addr
    // registers only load on their own source so they hold between beats.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dataValidQ <= 1'b0;
            dataOutQ   <= '0;
            dumpValidQ <= 1'b0;
            dumpAddrQ  <= '0;
            dumpDataQ  <= '0;
        end else begin
            dataValidQ <= pVld & (pTag == SRC_CPU);
            dumpValidQ <= pVld & (pTag == SRC_DUMP);
            if (pVld && pTag == SRC_CPU) dataOutQ <= pData;
            if (pVld && pTag == SRC_DUMP) begin
                dumpAddrQ <= pAddr;
                dumpDataQ <= pData;
            end
        end
    end

    // Dump sequencer. The counter stops at DEPTH-1; DRAIN waits for the last
    // dump read to leave the pipe so dumpDone follows the final beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            dumpCnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.dumpStart) begin
                        state   <= ST_DUMP;
                        dumpCnt <= '0;
                    end
                end
                ST_DUMP: begin
                    if (dumpIssue) begin
                        if (dumpCnt == '1) state <= ST_DRAIN;
                        else               dumpCnt <= dumpCnt + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (!dumpInFlight) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.dataOut   = dataOutQ;
    assign bus.dataValid = dataValidQ;
    assign bus.dumpValid = dumpValidQ;
    assign bus.dumpAddr  = dumpAddrQ;
    assign bus.dumpData  = dumpDataQ;
    assign bus.dumpBusy  = (state == ST_DUMP) || (state == ST_DRAIN);
    assign bus.dumpDone  = (state == ST_DONE);

endmodule

// File: tb/tb_dmem_pipe_dump.sv
// tb_dmem_pipe_dump: two instances (RD_LAT=1 and RD_LAT=3, ADDR_W=4) driven
// by the same directed stimulus; expected values are hand-derived constants.
module tb_dmem_pipe_dump;

    logic        clk = 1'b0;
    logic        reset;
    logic        memEn;
    logic        memWrEn;
    logic [0:3]  memAddr;
    logic [0:63] dataIn;
    logic [0:7]  byteWrMask;
    logic        dumpStart;

    always #5 clk = ~clk;

    dmem_pipe_dump_if #(.DATA_W(64), .ADDR_W(4)) if1 ();
    dmem_pipe_dump_if #(.DATA_W(64), .ADDR_W(4)) if3 ();

    assign if1.memEn      = memEn;
    assign if1.memWrEn    = memWrEn;
    assign if1.memAddr    = memAddr;
    assign if1.dataIn     = dataIn;
    assign if1.byteWrMask = byteWrMask;
    assign if1.dumpStart  = dumpStart;
    assign if3.memEn      = memEn;
    assign if3.memWrEn    = memWrEn;
    assign if3.memAddr    = memAddr;
    assign if3.dataIn     = dataIn;
    assign if3.byteWrMask = byteWrMask;
    assign if3.dumpStart  = dumpStart;

    dmem_pipe_dump #(.DATA_W(64), .ADDR_W(4), .RD_LAT(1), .BYTE_MASK_EN(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (if1)
    );

    dmem_pipe_dump #(.DATA_W(64), .ADDR_W(4), .RD_LAT(3), .BYTE_MASK_EN(1)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    int errCnt = 0;
    int chkCnt = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction
    function automatic logic fDataValid(input int d);
        return (d == 0) ? if1.dataValid : if3.dataValid;
    endfunction
    function automatic logic [63:0] fDataOut(input int d);
        return (d == 0) ? if1.dataOut : if3.dataOut;
    endfunction
    function automatic logic fDumpValid(input int d);
        return (d == 0) ? if1.dumpValid : if3.dumpValid;
    endfunction
    function automatic int fDumpAddr(input int d);
        return (d == 0) ? int'(if1.dumpAddr) : int'(if3.dumpAddr);
    endfunction
    function automatic logic [63:0] fDumpData(input int d);
        return (d == 0) ? if1.dumpData : if3.dumpData;
    endfunction
    function automatic logic fDumpBusy(input int d);
        return (d == 0) ? if1.dumpBusy : if3.dumpBusy;
    endfunction
    function automatic logic fDumpDone(input int d);
        return (d == 0) ? if1.dumpDone : if3.dumpDone;
    endfunction

    // Capture of output streams, per instance, sampled on the falling edge.
    int          dumpN   [2];
    int          dumpAddrR [2][128];
    logic [63:0] dumpDataR [2][128];
    int          rdN     [2];
    logic [63:0] rdR     [2][128];
    int          doneN   [2];
    int          doneCyc [2];
    int          bothN   [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (fDumpValid(d)) begin
                if (dumpN[d] < 128) begin
                    dumpAddrR[d][dumpN[d]] = fDumpAddr(d);
                    dumpDataR[d][dumpN[d]] = fDumpData(d);
                end
                dumpN[d] = dumpN[d] + 1;
            end
            if (fDataValid(d)) begin
                if (rdN[d] < 128) rdR[d][rdN[d]] = fDataOut(d);
                rdN[d] = rdN[d] + 1;
            end
            if (fDataValid(d) && fDumpValid(d)) bothN[d] = bothN[d] + 1;
            if (fDumpDone(d)) begin
                doneN[d]   = doneN[d] + 1;
                doneCyc[d] = cyc;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cpuWrite(input int a, input logic [63:0] d, input logic [7:0] m);
        memEn = 1'b1; memWrEn = 1'b1; memAddr = 4'(a); dataIn = d; byteWrMask = m;
        tick;
        memEn = 1'b0; memWrEn = 1'b0;
    endtask

    task automatic cpuRead(input int a);
        memEn = 1'b1; memWrEn = 1'b0; memAddr = 4'(a);
        tick;
        memEn = 1'b0;
    endtask

    // Checks the 16 beats starting at capture index base: addr i, data i,
    // except addr 15 which holds w15.
    task automatic chkDump(input string tag, input int d, input int base, input logic [63:0] w15);
        chk($sformatf("%s L%0d beats", tag, lat(d)), 64'(dumpN[d] - base), 64'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s L%0d addr%0d", tag, lat(d), i), 64'(dumpAddrR[d][base+i]), 64'(i));
            chk($sformatf("%s L%0d data%0d", tag, lat(d), i), dumpDataR[d][base+i],
                (i == 15) ? w15 : 64'(i));
        end
    endtask

    int bD [2];
    int bDone [2];
    int bRd [2];
    int s;

    initial begin
        reset = 1'b0; memEn = 1'b0; memWrEn = 1'b0; memAddr = '0;
        dataIn = '0; byteWrMask = '0; dumpStart = 1'b0;
        tick; tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst L%0d dataValid", lat(d)), 64'(fDataValid(d)), 64'd0);
            chk($sformatf("rst L%0d dumpValid", lat(d)), 64'(fDumpValid(d)), 64'd0);
            chk($sformatf("rst L%0d dumpBusy", lat(d)), 64'(fDumpBusy(d)), 64'd0);
            chk($sformatf("rst L%0d dumpDone", lat(d)), 64'(fDumpDone(d)), 64'd0);
            chk($sformatf("rst L%0d dataOut", lat(d)), fDataOut(d), 64'd0);
        end
        reset = 1'b1;
        tick;

        // Write then read addr 5: valid exactly RD_LAT edges after issue.
        cpuWrite(5, 64'h0123456789ABCDEF, 8'hFF);
        for (int t = 0; t <= 4; t++) begin
            if (t == 0) begin memEn = 1'b1; memWrEn = 1'b0; memAddr = 4'd5; end
            else memEn = 1'b0;
            tick;
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rd5 L%0d valid t%0d", lat(d), t), 64'(fDataValid(d)), 64'(t == lat(d)));
                if (t == lat(d))
                    chk($sformatf("rd5 L%0d data", lat(d)), fDataOut(d), 64'h0123456789ABCDEF);
            end
        end

        // Byte-lane masking on addr 7.
        cpuWrite(7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        cpuWrite(7, 64'h0, 8'b1000_0001);
        cpuRead(7);
        repeat (4) tick;
        for (int d = 0; d < 2; d++)
            chk($sformatf("mask81 L%0d", lat(d)), fDataOut(d), 64'h00FF_FFFF_FFFF_FF00);
        cpuWrite(7, 64'h0, 8'h00);
        cpuRead(5);
        repeat (4) tick;
        cpuRead(7);
        repeat (4) tick;
        for (int d = 0; d < 2; d++)
            chk($sformatf("mask00 L%0d", lat(d)), fDataOut(d), 64'h00FF_FFFF_FFFF_FF00);

        // Back-to-back reads of addrs 0..3.
        for (int i = 0; i < 4; i++) cpuWrite(i, 64'h10 + 64'(i), 8'hFF);
        for (int t = 0; t <= 7; t++) begin
            if (t < 4) begin memEn = 1'b1; memWrEn = 1'b0; memAddr = 4'(t); end
            else memEn = 1'b0;
            tick;
            for (int d = 0; d < 2; d++) begin
                int k;
                k = t - lat(d);
                chk($sformatf("b2b L%0d valid t%0d", lat(d), t), 64'(fDataValid(d)), 64'(k >= 0 && k <= 3));
                if (k >= 0 && k <= 3)
                    chk($sformatf("b2b L%0d data t%0d", lat(d), t), fDataOut(d), 64'h10 + 64'(k));
            end
        end

        // Preload MEM[i] = i.
        for (int i = 0; i < 16; i++) cpuWrite(i, 64'(i), 8'hFF);

        // Dump with the cpu idle; a second start while busy is ignored.
        for (int d = 0; d < 2; d++) begin bD[d] = dumpN[d]; bDone[d] = doneN[d]; end
        dumpStart = 1'b1;
        tick;
        s = cyc;
        for (int d = 0; d < 2; d++)
            chk($sformatf("dumpA L%0d busy", lat(d)), 64'(fDumpBusy(d)), 64'd1);
        tick;
        dumpStart = 1'b0;
        repeat (28) tick;
        for (int d = 0; d < 2; d++) begin
            chkDump("dumpA", d, bD[d], 64'd15);
            chk($sformatf("dumpA L%0d doneCnt", lat(d)), 64'(doneN[d] - bDone[d]), 64'd1);
            chk($sformatf("dumpA L%0d doneCyc", lat(d)), 64'(doneCyc[d] - s), 64'(17 + lat(d)));
            chk($sformatf("dumpA L%0d busyEnd", lat(d)), 64'(fDumpBusy(d)), 64'd0);
        end

        // Dump with cpu traffic every other cycle; write addr 15 before it is dumped.
        for (int d = 0; d < 2; d++) begin bD[d] = dumpN[d]; bDone[d] = doneN[d]; bRd[d] = rdN[d]; end
        dumpStart = 1'b1;
        tick;
        s = cyc;
        dumpStart = 1'b0;
        for (int m = 0; m < 50; m++) begin
            memEn = 1'b0; memWrEn = 1'b0;
            if (m % 2 == 1) begin
                memEn = 1'b1;
                if (m == 1) begin
                    memWrEn = 1'b1; memAddr = 4'd15; dataIn = 64'hF15; byteWrMask = 8'hFF;
                end else begin
                    memAddr = 4'((m / 2) % 16);
                end
            end
            tick;
        end
        memEn = 1'b0; memWrEn = 1'b0;
        repeat (5) tick;
        for (int d = 0; d < 2; d++) begin
            int n;
            chkDump("dumpB", d, bD[d], 64'hF15);
            chk($sformatf("dumpB L%0d doneCnt", lat(d)), 64'(doneN[d] - bDone[d]), 64'd1);
            chk($sformatf("dumpB L%0d doneCyc", lat(d)), 64'(doneCyc[d] - s), 64'(32 + lat(d)));
            chk($sformatf("dumpB L%0d cpuReads", lat(d)), 64'(rdN[d] - bRd[d]), 64'd24);
            n = 0;
            for (int m = 3; m < 50; m += 2) begin
                int a;
                a = (m / 2) % 16;
                chk($sformatf("dumpB L%0d cpuRd%0d", lat(d), a), rdR[d][bRd[d]+n],
                    (a == 15) ? 64'hF15 : 64'(a));
                n++;
            end
        end

        // Reset in place of issuing addr 6.
        for (int d = 0; d < 2; d++) begin bD[d] = dumpN[d]; bDone[d] = doneN[d]; end
        dumpStart = 1'b1;
        tick;
        dumpStart = 1'b0;
        repeat (6) tick;
        reset = 1'b0;
        tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rstDump L%0d busy", lat(d)), 64'(fDumpBusy(d)), 64'd0);
            chk($sformatf("rstDump L%0d dumpValid", lat(d)), 64'(fDumpValid(d)), 64'd0);
            chk($sformatf("rstDump L%0d beats", lat(d)), 64'(dumpN[d] - bD[d]), 64'(6 - lat(d)));
        end
        reset = 1'b1;
        repeat (25) tick;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rstDump L%0d beatsAfter", lat(d)), 64'(dumpN[d] - bD[d]), 64'(6 - lat(d)));
            chk($sformatf("rstDump L%0d noDone", lat(d)), 64'(doneN[d] - bDone[d]), 64'd0);
        end

        // Fresh dump after the abort: contents intact, normal completion.
        for (int d = 0; d < 2; d++) begin bD[d] = dumpN[d]; bDone[d] = doneN[d]; end
        dumpStart = 1'b1;
        tick;
        s = cyc;
        dumpStart = 1'b0;
        repeat (30) tick;
        for (int d = 0; d < 2; d++) begin
            chkDump("dumpC", d, bD[d], 64'hF15);
            chk($sformatf("dumpC L%0d doneCnt", lat(d)), 64'(doneN[d] - bDone[d]), 64'd1);
            chk($sformatf("dumpC L%0d doneCyc", lat(d)), 64'(doneCyc[d] - s), 64'(17 + lat(d)));
            chk($sformatf("excl L%0d bothValid", lat(d)), 64'(bothN[d]), 64'd0);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule

// File: doc/dmem_pipe_dump.md
Name: dmem_pipe_dump

Overview:
- Parametrised successor to the single-port 64-bit data memory used by the cpu/NIC benches.
- Generalised in data width, depth and read latency; adds byte-lane write masking.
- Adds a built-in dump sequencer that streams every word out on a dedicated port. Bench capture of memory no longer needs hierarchical MEM peeks, so it also works on the synthesised netlist.
- Sits between cpu dmem port and storage array; drop-in for cpu.dmem* signals when BYTE_MASK_EN=0 and RD_LAT=1.

Parameters:
- DATA_W, 64, data word width; must be a multiple of 8.
- ADDR_W, 8, word address width; depth = 2**ADDR_W.
- RD_LAT, 1, read latency in cycles; legal range 1..4.
- BYTE_MASK_EN, 1, 1 = honour byteWrMask; 0 = full-word writes only (mask ignored).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- memEn  in  1  cpu access request this cycle
- memWrEn  in  1  1 = write, 0 = read; qualified by memEn
- memAddr  in  [0:ADDR_W-1]  word address
- dataIn  in  [0:DATA_W-1]  write data
- byteWrMask  in  [0:DATA_W/8-1]  bit i enables byte dataIn[8i:8i+7]
- dataOut  out  [0:DATA_W-1]  read data
- dataValid  out  1  dataOut valid pulse
- dumpStart  in  1  pulse; begin full-memory dump
- dumpBusy  out  1  dump in progress
- dumpValid  out  1  dumpAddr/dumpData valid
- dumpAddr  out  [0:ADDR_W-1]  address of dumped word
- dumpData  out  [0:DATA_W-1]  dumped word
- dumpDone  out  1  one-cycle pulse after last word

Behaviour:
- Reset (reset==0 at posedge):
  - all outputs 0; FSM to IDLE; read pipeline flushed (no dataValid/dumpValid).
  - Array contents NOT cleared, so $readmemh preload survives reset.
- Write (memEn&memWrEn):
  - array updates at the same posedge.
  - Byte i written iff byteWrMask[i] (or BYTE_MASK_EN=0).
  - Mask all-zero = no change.
- Read (memEn&!memWrEn):
  - Issued at edge N; dataOut/dataValid registered at edge N+RD_LAT.
  - Fully pipelined, one read per cycle.
  - dataOut holds its last value when dataValid=0.
- Same-address read/write collisions (read issued after a write):
  - The single port never issues a read and a write in the same cycle.
  - A read issued the cycle after a write to the same address returns the new data; the write is in the array before the read samples.
- Dump FSM:
  - IDLE: dumpStart & reset high -> DUMP; dumpAddr counter := 0; dumpBusy=1.
  - DUMP:
    - Each cycle with memEn==0, issue an internal read of counter and increment it.
    - The cpu port always has priority; a cpu access stalls the dump for that cycle.
    - After issuing address DEPTH-1 -> DRAIN. The counter does not wrap.
  - DRAIN: wait until no dump reads are in flight -> DONE.
  - DONE: dumpDone=1 for one cycle, dumpBusy=0 -> IDLE.
- Dump outputs:
  - Dump reads share the RD_LAT pipeline, tagged by source.
  - dumpValid/dumpAddr/dumpData appear RD_LAT cycles after issue, strictly in ascending address order.
  - dataValid and dumpValid are never asserted together.
- Dump data is a snapshot per word at its issue time. cpu writes during a dump are visible only for addresses not yet issued.
- dumpStart while dumpBusy: ignored.
- Reset mid-dump: abort immediately; no dumpDone; in-flight results discarded.
- Out-of-range RD_LAT or non-multiple-of-8 DATA_W: elaboration error.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (IDLE, DUMP, DRAIN, DONE).
  - source tag constants (SRC_CPU, SRC_DUMP).
  - RD_LAT_MAX=4.
  - helper constant for byte-lane count.
- One sub-module dmem_rd_pipe:
  - RD_LAT-deep shift register of {valid, tag, addr, data}.
  - reset flush.
- Top holds the array, write-mask logic, arbitration and dump FSM.

Test Plan:
- Reset then write 64'h0123456789ABCDEF to addr 5, read addr 5 -> dataValid exactly RD_LAT cycles after issue, dataOut=64'h0123456789ABCDEF. Repeat for RD_LAT=1 and 3.
- Addr 7 holds 64'hFFFF_FFFF_FFFF_FFFF; write 64'h0 with byteWrMask=8'b1000_0001 -> read returns 64'h00FF_FFFF_FFFF_FF00. Mask 8'h00 -> unchanged.
- Back-to-back reads of addrs 0..3 on consecutive cycles, preloaded with 0x10..0x13 -> four consecutive dataValid pulses, values 0x10..0x13 in order.
- ADDR_W=4, preload MEM[i]=i, pulse dumpStart with cpu idle:
  - 16 dumpValid beats, dumpAddr 0..15, dumpData=i.
  - dumpDone at cycle 16+RD_LAT+1 relative to start.
  - second dumpStart while busy has no effect.
- Dump with cpu reads interleaved every other cycle:
  - cpu results remain correct with no lost dump beats.
  - dump duration grows by the number of stolen cycles.
  - a write to addr 15 before it is issued appears in the dump.
- Assert reset mid-dump at addr 6:
  - dumpBusy=0 and dumpValid=0 the next cycle; no dumpDone.
  - array contents intact; a fresh dump runs cleanly to completion.
